pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-stage program-counter controller for the pipelined MIPS core.
- Owns the PC register and sequences it: sequential fetch, hazard stall hold, ID-stage branch redirect and J-type jump redirect.
- Branch target = PC+4 plus the sign-extended word offset shifted left by 2.
- Generates the IF/ID flush and suppresses a redirect arriving from a flushed (bubble) ID slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counters (used only with the optional feature).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_offset  in  32  sign-extended immediate (word offset) of the ID branch.
- id_pc_plus4  in  32  PC+4 of the instruction currently in ID.
- jump  in  1  ID-stage J/JAL decoded.
- jump_index  in  26  instr[25:0] of the ID jump.
- pc  out  32  current fetch address (registered).
- pc_plus4  out  32  pc + 4, combinational, mod 2^32.
- fetch_valid  out  1  fetched instruction is valid (registered).
- if_flush  out  1  zero IF/ID at next edge (combinational).
- seq_state  out  2  FSM state, debug: 0 BOOT, 1 RUN, 2 STALL, 3 FLUSHED.

Behaviour:
- Reset (sync, clk edge with reset=1): pc=RESET_PC, fetch_valid=0, state=BOOT, if_flush=0. Reset has priority over all inputs.
- Reset mid-operation discards any pending redirect.
- Targets:
  - br_tgt = id_pc_plus4 + {branch_offset[29:0],2'b00}, mod 2^32; overflow ignored.
  - j_tgt = {id_pc_plus4[31:28], jump_index, 2'b00}.
- Priority in RUN/STALL: stall > jump > branch_taken > sequential.
- BOOT:
  - Inputs ignored; pc held; fetch_valid=0.
  - Next state is RUN, with fetch_valid=1 from that edge.
- RUN:
  - stall=1: pc held, state -> STALL, if_flush=0.
  - Else jump=1: if_flush=1 this cycle; pc <= j_tgt; state -> FLUSHED.
  - Else branch_taken=1: if_flush=1; pc <= br_tgt; state -> FLUSHED.
  - Else: pc <= pc+4; stay RUN.
- STALL:
  - stall=1: hold, no flush, jump/branch ignored (ID operands not yet valid).
  - stall=0: same decision as RUN in that cycle.
- FLUSHED (ID holds a bubble for exactly this one cycle):
  - jump and branch_taken ignored; if_flush=0.
  - stall=1 -> hold, go STALL; else pc <= pc+4, go RUN.
- Redirect latency: redirect decided in cycle N; pc = target in cycle N+1; wrong-path instruction killed by if_flush in cycle N.
- Simultaneous jump and branch_taken: jump wins.
- pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 on sequential fetch.
- fetch_valid is 0 only in BOOT.

Optional Feature:
- Macro: PC_SEQ_REDIRECT_CNT_EN.
- Defined:
  - Adds outputs jump_cnt[CNT_W-1:0] and branch_cnt[CNT_W-1:0].
  - Each increments at the edge where its redirect is accepted (RUN/STALL-exit, not stall).
  - Counters saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, no stall -> seq_state BOOT one cycle, then pc = 0x0, 0x4, 0x8; fetch_valid 0 then 1.
- RUN, branch_taken=1, id_pc_plus4=0x10, branch_offset=0xFFFFFFFE -> if_flush=1 that cycle, next pc=0x08, seq_state=FLUSHED, then 0x0C.
- jump=1 and branch_taken=1 together, id_pc_plus4=0x40000004, jump_index=0x0000100 -> next pc=0x40000400, branch ignored.
- stall=1 for 3 cycles with branch_taken=1 -> pc held, if_flush=0; branch taken on the cycle stall drops.
- In FLUSHED, branch_taken=1 -> ignored, pc advances by 4; wrap case: id_pc_plus4=0xFFFFFFFC, offset=1 -> pc=0x00000000.
- With PC_SEQ_REDIRECT_CNT_EN, CNT_W=2: 5 accepted branches -> branch_cnt=3 (saturated); reset mid-redirect -> pc=RESET_PC, counters 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential fetch, stall hold, branch and jump redirect.
// Optional redirect counters are enabled by defining PC_SEQ_REDIRECT_CNT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] id_pc_plus4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        if_flush,
  output logic [1:0]  seq_state
`ifdef PC_SEQ_REDIRECT_CNT_EN
  ,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] branch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_STALL   = 2'd2,
    S_FLUSHED = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        jump_acc;
  logic        br_acc;
  logic        unused_offset_hi;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  // Redirect targets; the top two offset bits fall off the word-to-byte shift.
  assign br_tgt           = id_pc_plus4 + {branch_offset[29:0], 2'b00};
  assign j_tgt            = {id_pc_plus4[31:28], jump_index, 2'b00};
  assign unused_offset_hi = ^branch_offset[31:30];

  assign pc_plus4  = pc + 32'd4;
  assign seq_state = state;

  // State, PC and fetch-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_valid <= (state_nxt != S_BOOT);
    end
  end

  // Next-state, next-PC and flush decision.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if_flush  = 1'b0;
    jump_acc  = 1'b0;
    br_acc    = 1'b0;
    unique case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (stall) begin
          state_nxt = S_STALL;
        end else if (jump) begin
          if_flush  = 1'b1;
          pc_nxt    = j_tgt;
          state_nxt = S_FLUSHED;
          jump_acc  = 1'b1;
        end else if (branch_taken) begin
          if_flush  = 1'b1;
          pc_nxt    = br_tgt;
          state_nxt = S_FLUSHED;
          br_acc    = 1'b1;
        end else begin
          pc_nxt    = pc_plus4;
          state_nxt = S_RUN;
        end
      end
      S_FLUSHED: begin
        // ID holds a bubble: any redirect seen here is stale.
        if (stall) begin
          state_nxt = S_STALL;
        end else begin
          pc_nxt    = pc_plus4;
          state_nxt = S_RUN;
        end
      end
    endcase
    if (reset) begin
      if_flush = 1'b0;
      jump_acc = 1'b0;
      br_acc   = 1'b0;
    end
  end

`ifdef PC_SEQ_REDIRECT_CNT_EN
  // Saturating counts of accepted redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_cnt   <= '0;
      branch_cnt <= '0;
    end else begin
      if (jump_acc && (jump_cnt != {CNT_W{1'b1}})) begin
        jump_cnt <= jump_cnt + CNT_W'(1);
      end
      if (br_acc && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_acc;
  assign unused_acc = jump_acc | br_acc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; redirect counters are checked when PC_SEQ_REDIRECT_CNT_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQ_REDIRECT_CNT_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] id_pc_plus4;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        if_flush;
  logic [1:0]  seq_state;
`ifdef PC_SEQ_REDIRECT_CNT_EN
  logic [CNT_W-1:0] jump_cnt;
  logic [CNT_W-1:0] branch_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .id_pc_plus4  (id_pc_plus4),
    .jump         (jump),
    .jump_index   (jump_index),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .if_flush     (if_flush),
    .seq_state    (seq_state)
`ifdef PC_SEQ_REDIRECT_CNT_EN
    ,
    .jump_cnt     (jump_cnt),
    .branch_cnt   (branch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = 32'h0; id_pc_plus4 = 32'h0; jump_index = 26'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_fv", 32'(fetch_valid), 32'h0);
    check("rst_state", 32'(seq_state), 32'h0);
    check("rst_flush", 32'(if_flush), 32'h0);

    // Boot then sequential fetch
    reset = 1'b0;
    #1 check("boot_state", 32'(seq_state), 32'h0);
    tick();
    check("run_state", 32'(seq_state), 32'h1);
    check("run_pc0", pc, 32'h0);
    check("run_fv", 32'(fetch_valid), 32'h1);
    tick(); check("run_pc4", pc, 32'h4);
    tick(); check("run_pc8", pc, 32'h8);

    // Backward branch: 0x10 + (-2 words) = 0x08; stale branch in FLUSHED ignored
    branch_taken = 1'b1; id_pc_plus4 = 32'h10; branch_offset = 32'hFFFF_FFFE;
    #1 check("br_flush", 32'(if_flush), 32'h1);
    tick();
    check("br_pc", pc, 32'h8);
    check("br_state", 32'(seq_state), 32'h3);
    check("flushed_noflush", 32'(if_flush), 32'h0);
    tick();
    check("flushed_pc", pc, 32'hC);
    check("flushed_run", 32'(seq_state), 32'h1);
    idle();

    // Jump beats branch
    jump = 1'b1; branch_taken = 1'b1; id_pc_plus4 = 32'h4000_0004;
    jump_index = 26'h000_0100; branch_offset = 32'h4;
    #1 check("jb_flush", 32'(if_flush), 32'h1);
    tick();
    check("jb_pc", pc, 32'h4000_0400);
    idle();
    tick(); check("jb_seq", pc, 32'h4000_0404);

    // Stall 3 cycles with a pending branch, taken when stall drops
    stall = 1'b1; branch_taken = 1'b1; id_pc_plus4 = 32'h100; branch_offset = 32'h4;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_flush", 32'(if_flush), 32'h0);
      tick();
      check("stall_pc", pc, 32'h4000_0404);
      check("stall_state", 32'(seq_state), 32'h2);
    end
    stall = 1'b0;
    #1 check("unstall_flush", 32'(if_flush), 32'h1);
    tick();
    check("unstall_pc", pc, 32'h110);
    idle();
    tick(); check("unstall_seq", pc, 32'h114);

    // Jump to top of memory, stall in FLUSHED, then wrap on sequential fetch
    jump = 1'b1; id_pc_plus4 = 32'hF000_0000; jump_index = 26'h3FF_FFFF;
    tick();
    check("wrapj_pc", pc, 32'hFFFF_FFFC);
    check("wrapj_pc4", pc_plus4, 32'h0);
    idle();
    stall = 1'b1;
    tick();
    check("fl_stall_state", 32'(seq_state), 32'h2);
    check("fl_stall_pc", pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    tick();
    check("wrap_seq_pc", pc, 32'h0);
    check("wrap_seq_state", 32'(seq_state), 32'h1);

    // Branch target wraps: 0xFFFFFFFC + 4 = 0
    branch_taken = 1'b1; id_pc_plus4 = 32'hFFFF_FFFC; branch_offset = 32'h1;
    tick();
    check("wrapb_pc", pc, 32'h0);
    idle();
    tick(); check("wrapb_seq", pc, 32'h4);

`ifdef PC_SEQ_REDIRECT_CNT_EN
    // Three branches and two jumps accepted so far; five more branches saturate
    for (int i = 0; i < 5; i++) begin
      branch_taken = 1'b1; id_pc_plus4 = 32'h20; branch_offset = 32'h0;
      tick();
      idle();
      tick();
    end
    check("bcnt_sat", 32'(branch_cnt), 32'h3);
    check("jcnt", 32'(jump_cnt), 32'h2);
`endif

    // Reset arriving with a redirect pending
    branch_taken = 1'b1; id_pc_plus4 = 32'h200; branch_offset = 32'h0;
    reset = 1'b1;
    #1 check("rstmid_flush", 32'(if_flush), 32'h0);
    tick();
    check("rstmid_pc", pc, 32'h0);
    check("rstmid_state", 32'(seq_state), 32'h0);
    check("rstmid_fv", 32'(fetch_valid), 32'h0);
`ifdef PC_SEQ_REDIRECT_CNT_EN
    check("rstmid_bcnt", 32'(branch_cnt), 32'h0);
    check("rstmid_jcnt", 32'(jump_cnt), 32'h0);
`endif
    reset = 1'b0;
    idle();
    tick();
    check("rstmid_run_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
